pipelined_multiplier: RTL and testbench

- Parametrised multiplier, successor to the fixed-latency dummy multiplier, with a configurable pipeline depth.
- Adds per-request signed/unsigned mode, a pass-through tag and valid/ready handshakes on both sides.
- Each stage has its own valid bit, so bubbles collapse; full throughput is one product per clock.
- Sits between a request producer and a result consumer in datapath examples and bench infrastructure.

---
 rtl/pipelined_multiplier.sv | 118 +++++++++++
 tb/tb_pipelined_multiplier.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_multiplier.sv
// Pipelined WL x WL multiplier with per-request signed/unsigned mode, an opaque tag,
// per-stage valid bits (bubbles collapse) and valid/ready handshakes on both sides.
module pipelined_multiplier #(
    parameter int WL       = 32,
    parameter int PIPE_LVL = 4,
    parameter int TAG_W    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_signed,
    input  logic [WL-1:0]                   multiplier,
    input  logic [WL-1:0]                   multiplicand,
    input  logic [TAG_W-1:0]                in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*WL-1:0]                 product,
    output logic [TAG_W-1:0]                out_tag,
    output logic [$clog2(PIPE_LVL+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(PIPE_LVL+1);

    // Handshake: a transfer happens on a rising edge where valid && ready. A producer
    // holds valid and data until it sees ready; ready never waits on valid. in_ready is
    // combinational from out_ready through the stage-advance chain.

    logic [PIPE_LVL-1:0] v;
    logic [PIPE_LVL-1:0] adv;
    logic [PIPE_LVL-1:0] en;
    logic [2*WL-1:0]     prod_q [PIPE_LVL];
    logic [TAG_W-1:0]    tag_q  [PIPE_LVL];

    logic                src_v [PIPE_LVL];
    logic [2*WL-1:0]     src_p [PIPE_LVL];
    logic [TAG_W-1:0]    src_t [PIPE_LVL];

    logic [2*WL-1:0]     ext_a;
    logic [2*WL-1:0]     ext_b;
    logic [2*WL-1:0]     mul_full;
    logic                accept;
    logic                done;

    // Sign-extending both operands to 2*WL makes the truncated product exact in both modes.
    always_comb begin
        ext_a    = {{WL{in_signed & multiplier[WL-1]}}, multiplier};
        ext_b    = {{WL{in_signed & multiplicand[WL-1]}}, multiplicand};
        mul_full = ext_a * ext_b;
    end

    always_comb begin
        adv = '0;
        en  = '0;
        adv[PIPE_LVL-1] = !v[PIPE_LVL-1] || out_ready;
        for (int k = PIPE_LVL-2; k >= 0; k--) begin
            adv[k] = !v[k+1] || adv[k+1];
        end
        // A stage may load when it is empty (bubble) or its content moves on.
        for (int k = 0; k < PIPE_LVL; k++) begin
            en[k] = !v[k] || adv[k];
        end
    end

    always_comb begin
        for (int k = 0; k < PIPE_LVL; k++) begin
            src_v[k] = 1'b0;
            src_p[k] = '0;
            src_t[k] = '0;
        end
        src_v[0] = in_valid;
        src_p[0] = mul_full;
        src_t[0] = in_tag;
        for (int k = 1; k < PIPE_LVL; k++) begin
            src_v[k] = v[k-1];
            src_p[k] = prod_q[k-1];
            src_t[k] = tag_q[k-1];
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v[PIPE_LVL-1];
    assign product   = prod_q[PIPE_LVL-1];
    assign out_tag   = tag_q[PIPE_LVL-1];
    assign accept    = in_valid && in_ready;
    assign done      = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < PIPE_LVL; k++) begin
                prod_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_LVL; k++) begin
                if (en[k]) begin
                    v[k] <= src_v[k];
                    if (src_v[k]) begin
                        prod_q[k] <= src_p[k];
                        tag_q[k]  <= src_t[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (accept && !done) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (done && !accept) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Bench for pipelined_multiplier: a queue-based reference model checks every cycle of a
// PIPE_LVL=4 instance; a second PIPE_LVL=1 instance gets directed checks.
module tb_pipelined_multiplier;

    localparam int WL = 8;
    localparam int L  = 4;
    localparam int TW = 4;
    localparam int OW = $clog2(L+1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [WL-1:0]   a, b;
    logic [TW-1:0]   in_tag, out_tag;
    logic [2*WL-1:0] product;
    logic [OW-1:0]   occupancy;

    logic            in_valid_1, in_ready_1, in_signed_1, out_valid_1, out_ready_1;
    logic [WL-1:0]   a_1, b_1;
    logic [TW-1:0]   in_tag_1, out_tag_1;
    logic [2*WL-1:0] product_1;
    logic [0:0]      occupancy_1;

    pipelined_multiplier #(.WL(WL), .PIPE_LVL(L), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .multiplier(a), .multiplicand(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .out_tag(out_tag), .occupancy(occupancy)
    );

    pipelined_multiplier #(.WL(WL), .PIPE_LVL(1), .TAG_W(TW)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_signed(in_signed_1), .multiplier(a_1), .multiplicand(b_1), .in_tag(in_tag_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .product(product_1),
        .out_tag(out_tag_1), .occupancy(occupancy_1)
    );

    logic [2*WL+TW-1:0] exp_q[$];
    int                 rdy_q[$];
    int                 cyc;
    int                 compared;
    int                 mismatched;

    function automatic logic [2*WL-1:0] ref_mul(logic s, logic [WL-1:0] x, logic [WL-1:0] y);
        int ix, iy;
        if (s) begin
            ix = int'($signed(x));
            iy = int'($signed(y));
        end else begin
            ix = int'(x);
            iy = int'(y);
        end
        return 16'(ix * iy);
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock of the L=4 instance: check outputs against the model, then apply the edge.
    task automatic tick();
        logic               m_rdy, m_ov, acc, dn;
        logic [2*WL+TW-1:0] ent;
        #1;
        m_rdy = (exp_q.size() < L) || out_ready;
        m_ov  = (exp_q.size() > 0) && (cyc >= rdy_q[0]);
        check("in_ready", 64'(in_ready), 64'(m_rdy));
        check("occupancy", 64'(occupancy), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            check("product", 64'(product), 64'(exp_q[0][2*WL+TW-1:TW]));
            check("out_tag", 64'(out_tag), 64'(exp_q[0][TW-1:0]));
        end
        acc = in_valid && m_rdy;
        dn  = m_ov && out_ready;
        ent = {ref_mul(in_signed, a, b), in_tag};
        @(posedge clk);
        cyc++;
        if (dn) begin
            void'(exp_q.pop_front());
            void'(rdy_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back(ent);
            rdy_q.push_back(cyc + L - 1);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        #1;
        check("drain_occupancy", 64'(occupancy), 64'(0));
    endtask

    task automatic send_one(input string name, input logic s, input logic [WL-1:0] x,
                            input logic [WL-1:0] y, input logic [TW-1:0] t,
                            input logic [2*WL-1:0] exp_p);
        int n;
        in_valid  = 1'b1;
        in_signed = s;
        a         = x;
        b         = y;
        in_tag    = t;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(L - 1));
        check({name, "_product"}, 64'(product), 64'(exp_p));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        reset      = 1'b1;
        in_valid   = 1'b0; in_signed   = 1'b0; a   = '0; b   = '0; in_tag   = '0; out_ready   = 1'b1;
        in_valid_1 = 1'b0; in_signed_1 = 1'b0; a_1 = '0; b_1 = '0; in_tag_1 = '0; out_ready_1 = 1'b1;

        // Reset values
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst1_out_valid", 64'(out_valid_1), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Basic and signed/unsigned directed products
        send_one("basic", 1'b0, 8'd200, 8'd100, 4'd3, 16'h4E20);
        send_one("s_m3x5", 1'b1, 8'hFD, 8'h05, 4'd1, 16'hFFF1);
        send_one("s_m128sq", 1'b1, 8'h80, 8'h80, 4'd2, 16'h4000);
        send_one("s_127xm128", 1'b1, 8'h7F, 8'h80, 4'd4, 16'hC080);
        send_one("u_253x5", 1'b0, 8'hFD, 8'h05, 4'd5, 16'h04F1);
        send_one("u_max", 1'b0, 8'hFF, 8'hFF, 4'd15, 16'hFE01);

        // Streaming: 20 back-to-back random requests
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_signed = 1'($urandom_range(0, 1));
            a         = 8'($urandom);
            b         = 8'($urandom);
            in_tag    = 4'($urandom);
            #1;
            check("stream_in_ready", 64'(in_ready), 64'(1));
            tick();
        end
        #1;
        check("stream_occupancy", 64'(occupancy), 64'(L));
        drain();

        // Backpressure: requests held until accepted
        out_ready = 1'b0;
        acc_n     = 0;
        in_valid  = 1'b1;
        in_signed = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom); in_tag = 4'($urandom);
        for (int i = 0; i < 8; i++) begin
            #1;
            if (in_ready === 1'b1) begin
                acc_n++;
                tick();
                in_signed = 1'($urandom_range(0, 1));
                a = 8'($urandom); b = 8'($urandom); in_tag = 4'($urandom);
            end else begin
                tick();
            end
        end
        #1;
        check("bp_accepted", 64'(acc_n), 64'(4));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_occupancy", 64'(occupancy), 64'(L));
        drain();

        // Full pass-through: accept and emit on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < L; i++) begin
            in_valid = 1'b1;
            in_signed = 1'($urandom_range(0, 1));
            a = 8'($urandom); b = 8'($urandom); in_tag = 4'(i);
            tick();
        end
        out_ready = 1'b1;
        in_tag    = 4'd9;
        a = 8'($urandom); b = 8'($urandom);
        tick();
        in_valid = 1'b0;
        #1;
        check("pass_occupancy", 64'(occupancy), 64'(L));
        drain();

        // Reset mid-flight with 3 requests in flight and one at the output
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_signed = 1'($urandom_range(0, 1));
            a = 8'($urandom); b = 8'($urandom); in_tag = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();
        #1;
        check("pre_rst_out_valid", 64'(out_valid), 64'(1));
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_product", 64'(product), 64'(0));
        check("mid_rst_out_tag", 64'(out_tag), 64'(0));
        check("mid_rst_occupancy", 64'(occupancy), 64'(0));
        exp_q.delete();
        rdy_q.delete();
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // PIPE_LVL=1 instance: one-edge latency, stall and same-edge pass-through
        in_valid_1 = 1'b1; in_signed_1 = 1'b0; a_1 = 8'd200; b_1 = 8'd100; in_tag_1 = 4'd3;
        out_ready_1 = 1'b1;
        #1;
        check("p1_in_ready", 64'(in_ready_1), 64'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid_1 = 1'b0;
        #1;
        check("p1_out_valid", 64'(out_valid_1), 64'(1));
        check("p1_product", 64'(product_1), 64'(16'h4E20));
        check("p1_out_tag", 64'(out_tag_1), 64'(3));
        check("p1_occupancy", 64'(occupancy_1), 64'(1));
        out_ready_1 = 1'b0;
        in_valid_1 = 1'b1; in_signed_1 = 1'b1; a_1 = 8'hF9; b_1 = 8'h09; in_tag_1 = 4'd5;
        #1;
        check("p1_stall_in_ready", 64'(in_ready_1), 64'(0));
        @(posedge clk);
        @(negedge clk);
        #1;
        check("p1_hold_product", 64'(product_1), 64'(16'h4E20));
        check("p1_hold_out_tag", 64'(out_tag_1), 64'(3));
        out_ready_1 = 1'b1;
        #1;
        check("p1_pass_in_ready", 64'(in_ready_1), 64'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid_1 = 1'b0;
        #1;
        check("p1_pass_product", 64'(product_1), 64'(16'hFFC1));
        check("p1_pass_out_tag", 64'(out_tag_1), 64'(5));
        check("p1_pass_occupancy", 64'(occupancy_1), 64'(1));
        @(posedge clk);
        @(negedge clk);
        #1;
        check("p1_empty_out_valid", 64'(out_valid_1), 64'(0));
        check("p1_empty_occupancy", 64'(occupancy_1), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
